// File: rtl/nco_sweep_controller.sv
// ---------------------------------------------------------------------------
// nco_sweep_controller
//
// Drives the NCO phase increment and sample enable to run stepped frequency
// sweeps. A start pulse in IDLE latches a sweep descriptor into shadow
// registers. Each frequency is then held for a programmable number of sample
// enables before the increment is stepped. The sweep either ends with a
// one-cycle done pulse (single-shot) or wraps back to the first frequency
// (continuous) until aborted.
//
// Ports
//   clk              system clock (shared with the NCO)
//   arst             synchronous active-high reset, highest priority
//   sample_clk_ce    sample-rate enable, same strobe the NCO uses
//   start            one-cycle sweep request, honoured only in IDLE
//   abort            stop the sweep immediately, wins over start
//   cont_mode        0 = single-shot, 1 = wrap to the first frequency forever
//   start_increment  first phase increment
//   step_increment   signed delta added per step (two's complement)
//   num_steps        number of frequencies (0 treated as 1)
//   dwell_samples    sample enables per frequency (0 treated as 1)
//   phase_increment  registered increment to the NCO
//   nco_ce           sample_clk_ce gated by busy, to the NCO
//   busy             high while dwelling on a frequency
//   done             one-cycle pulse at the end of a single-shot sweep
//   step_index       0-based index of the current frequency
// ---------------------------------------------------------------------------
module nco_sweep_controller #(
  parameter int PHASE_WIDTH = 64,
  parameter int COUNT_WIDTH = 16,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   sample_clk_ce,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   cont_mode,
  input  logic [PHASE_WIDTH-1:0] start_increment,
  input  logic [PHASE_WIDTH-1:0] step_increment,
  input  logic [COUNT_WIDTH-1:0] num_steps,
  input  logic [DWELL_WIDTH-1:0] dwell_samples,
  output logic [PHASE_WIDTH-1:0] phase_increment,
  output logic                   nco_ce,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] step_index
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state_reg, state_next;

  // Shadow copy of the descriptor. The step count and dwell length are
  // stored as "last index" values so the zero-means-one rule is resolved
  // once at latch time and the compare paths stay simple equality checks.
  logic                   cont_reg, cont_next;
  logic [PHASE_WIDTH-1:0] start_inc_reg, start_inc_next;
  logic [PHASE_WIDTH-1:0] step_inc_reg, step_inc_next;
  logic [COUNT_WIDTH-1:0] last_idx_reg, last_idx_next;
  logic [DWELL_WIDTH-1:0] dwell_last_reg, dwell_last_next;

  logic [PHASE_WIDTH-1:0] phase_reg, phase_next;
  logic [COUNT_WIDTH-1:0] idx_reg, idx_next;
  logic [DWELL_WIDTH-1:0] cnt_reg, cnt_next;

  logic                   dwell_end;
  logic                   last_step;

  assign dwell_end = sample_clk_ce && (cnt_reg == dwell_last_reg);
  assign last_step = (idx_reg == last_idx_reg);

  always_comb begin
    state_next      = state_reg;
    cont_next       = cont_reg;
    start_inc_next  = start_inc_reg;
    step_inc_next   = step_inc_reg;
    last_idx_next   = last_idx_reg;
    dwell_last_next = dwell_last_reg;
    phase_next      = phase_reg;
    idx_next        = idx_reg;
    cnt_next        = cnt_reg;

    if (abort) begin
      state_next = IDLE;
      phase_next = '0;
      idx_next   = '0;
      cnt_next   = '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            cont_next       = cont_mode;
            start_inc_next  = start_increment;
            step_inc_next   = step_increment;
            last_idx_next   = (num_steps == '0) ? '0 : num_steps - COUNT_WIDTH'(1);
            dwell_last_next = (dwell_samples == '0) ? '0
                                                    : dwell_samples - DWELL_WIDTH'(1);
            phase_next      = start_increment;
            idx_next        = '0;
            cnt_next        = '0;
            state_next      = DWELL;
          end
        end

        DWELL: begin
          // The new increment lands on the same edge as the final dwell
          // enable, so the next NCO enable already sees the new frequency.
          if (dwell_end) begin
            cnt_next = '0;
            if (!last_step) begin
              phase_next = phase_reg + step_inc_reg;
              idx_next   = idx_reg + COUNT_WIDTH'(1);
            end else if (cont_reg) begin
              phase_next = start_inc_reg;
              idx_next   = '0;
            end else begin
              state_next = DONE;
            end
          end else if (sample_clk_ce) begin
            cnt_next = cnt_reg + DWELL_WIDTH'(1);
          end
        end

        DONE: begin
          state_next = IDLE;
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_reg      <= IDLE;
      cont_reg       <= 1'b0;
      start_inc_reg  <= '0;
      step_inc_reg   <= '0;
      last_idx_reg   <= '0;
      dwell_last_reg <= '0;
      phase_reg      <= '0;
      idx_reg        <= '0;
      cnt_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      cont_reg       <= cont_next;
      start_inc_reg  <= start_inc_next;
      step_inc_reg   <= step_inc_next;
      last_idx_reg   <= last_idx_next;
      dwell_last_reg <= dwell_last_next;
      phase_reg      <= phase_next;
      idx_reg        <= idx_next;
      cnt_reg        <= cnt_next;
    end
  end

  assign busy            = (state_reg == DWELL);
  assign done            = (state_reg == DONE);
  assign nco_ce          = sample_clk_ce & busy;
  assign phase_increment = phase_reg;
  assign step_index      = idx_reg;

endmodule

// File: tb/tb_nco_sweep_controller.sv
// Directed bench for nco_sweep_controller: reset, up-sweep, wrapping
// down-sweep, continuous mode with abort, degenerate descriptor, handshake.
module tb_nco_sweep_controller;

  localparam int PW = 64;
  localparam int CW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          arst;
  logic          sample_clk_ce;
  logic          start;
  logic          abort;
  logic          cont_mode;
  logic [PW-1:0] start_increment;
  logic [PW-1:0] step_increment;
  logic [CW-1:0] num_steps;
  logic [DW-1:0] dwell_samples;
  logic [PW-1:0] phase_increment;
  logic          nco_ce;
  logic          busy;
  logic          done;
  logic [CW-1:0] step_index;

  int n_assert = 0;
  int n_fail   = 0;

  nco_sweep_controller #(
    .PHASE_WIDTH(PW),
    .COUNT_WIDTH(CW),
    .DWELL_WIDTH(DW)
  ) dut (
    .clk             (clk),
    .arst            (arst),
    .sample_clk_ce   (sample_clk_ce),
    .start           (start),
    .abort           (abort),
    .cont_mode       (cont_mode),
    .start_increment (start_increment),
    .step_increment  (step_increment),
    .num_steps       (num_steps),
    .dwell_samples   (dwell_samples),
    .phase_increment (phase_increment),
    .nco_ce          (nco_ce),
    .busy            (busy),
    .done            (done),
    .step_index      (step_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs may then be driven and outputs sampled 1 ns
  // after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep(input logic cm, input logic [PW-1:0] si,
                             input logic [PW-1:0] st, input logic [CW-1:0] ns,
                             input logic [DW-1:0] dw);
    cont_mode       = cm;
    start_increment = si;
    step_increment  = st;
    num_steps       = ns;
    dwell_samples   = dw;
    sample_clk_ce   = 1'b0;
    start           = 1'b1;
    step();
    start = 1'b0;
    $display("start: cont=%0d si=%0d st=%0h ns=%0d dw=%0d busy=%0d phase=%0d",
             cm, si, st, ns, dw, busy, phase_increment);
  endtask

  logic [PW-1:0] exp_up [4];
  int            pulses;
  int            dones;
  logic [PW-1:0] exp_phase;
  logic [CW-1:0] exp_idx_seq [9];

  initial begin
    exp_up[0] = 64'd1000;
    exp_up[1] = 64'd1250;
    exp_up[2] = 64'd1500;
    exp_up[3] = 64'd1750;
    exp_idx_seq = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd2, 16'd2, 16'd0, 16'd0, 16'd1};

    arst = 1'b1; sample_clk_ce = 1'b1; start = 1'b0; abort = 1'b0;
    cont_mode = 1'b0; start_increment = '0; step_increment = '0;
    num_steps = '0; dwell_samples = '0;

    // ---------------- reset state ----------------
    step(); step();
    chk("rst_phase", phase_increment, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", step_index, 0);
    chk("rst_nco_ce", nco_ce, 0);
    arst = 1'b0;
    step();

    // ---------------- single-shot up-sweep + handshake ----------------
    start_sweep(1'b0, 64'd1000, 64'd250, 16'd4, 16'd3);
    chk("up_busy_after_start", busy, 1);
    chk("up_phase_after_start", phase_increment, 1000);
    pulses = 0;
    dones  = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      sample_clk_ce = (cyc % 2 == 0);
      if (cyc == 3) begin
        // Descriptor changes and a start while dwelling must have no effect.
        cont_mode = 1'b1; start_increment = 64'd7; step_increment = 64'd9;
        num_steps = 16'd1; dwell_samples = 16'd1; start = 1'b1;
      end
      if (cyc == 4) start = 1'b0;
      #1;
      if (nco_ce) begin
        exp_phase = (pulses < 12) ? exp_up[pulses / 3] : 64'd0;
        chk($sformatf("up_pulse%0d_phase", pulses), phase_increment, exp_phase);
        $display("up: pulse=%0d phase=%0d idx=%0d", pulses, phase_increment, step_index);
        pulses++;
      end
      step();
      if (done) begin
        dones++;
        chk("up_done_after_12", pulses, 12);
      end
    end
    chk("up_pulse_count", pulses, 12);
    chk("up_done_count", dones, 1);
    chk("up_final_phase", phase_increment, 1750);
    chk("up_busy_end", busy, 0);
    sample_clk_ce = 1'b0;
    step();

    // ---------------- down-sweep with wrap ----------------
    start_sweep(1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FF38, 16'd2, 16'd1);
    sample_clk_ce = 1'b1;
    #1;
    chk("dn_ce0", nco_ce, 1);
    chk("dn_phase0", phase_increment, 100);
    $display("down: pulse=0 phase=%0d", phase_increment);
    step();
    chk("dn_ce1", nco_ce, 1);
    chk("dn_phase1", phase_increment, 64'hFFFF_FFFF_FFFF_FF9C);
    $display("down: pulse=1 phase=%0h", phase_increment);
    step();
    chk("dn_done", done, 1);
    chk("dn_busy", busy, 0);
    chk("dn_ce_off", nco_ce, 0);
    step();
    chk("dn_done_clear", done, 0);
    sample_clk_ce = 1'b0;

    // ---------------- continuous mode then abort ----------------
    start_sweep(1'b1, 64'd500, 64'd10, 16'd3, 16'd2);
    sample_clk_ce = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk($sformatf("cont_idx%0d", i), step_index, exp_idx_seq[i]);
      chk($sformatf("cont_phase%0d", i), phase_increment,
          64'd500 + 64'd10 * 64'(exp_idx_seq[i]));
      chk($sformatf("cont_nodone%0d", i), done, 0);
      $display("cont: pulse=%0d idx=%0d phase=%0d", i, step_index, phase_increment);
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_phase", phase_increment, 0);
    chk("abort_idx", step_index, 0);
    chk("abort_ce", nco_ce, 0);
    chk("abort_done", done, 0);
    step();
    chk("abort_done_later", done, 0);
    sample_clk_ce = 1'b0;

    // ---------------- degenerate descriptor ----------------
    start_sweep(1'b0, 64'd77, 64'd5, 16'd0, 16'd0);
    sample_clk_ce = 1'b1;
    #1;
    chk("deg_ce", nco_ce, 1);
    chk("deg_phase", phase_increment, 77);
    step();
    chk("deg_done", done, 1);
    chk("deg_ce_off", nco_ce, 0);
    step();
    chk("deg_done_clear", done, 0);
    chk("deg_phase_hold", phase_increment, 77);
    $display("degenerate: phase=%0d busy=%0d", phase_increment, busy);
    sample_clk_ce = 1'b0;

    // ---------------- simultaneous start + abort in IDLE ----------------
    start = 1'b1; abort = 1'b1; start_increment = 64'd333;
    step();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_phase", phase_increment, 0);
    $display("start+abort: busy=%0d phase=%0d", busy, phase_increment);

    // ---------------- reset mid-sweep ----------------
    start_sweep(1'b0, 64'd4000, 64'd1, 16'd5, 16'd5);
    sample_clk_ce = 1'b1;
    step(); step();
    chk("mid_busy_before_rst", busy, 1);
    arst = 1'b1;
    step();
    chk("mid_rst_phase", phase_increment, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_idx", step_index, 0);
    chk("mid_rst_ce", nco_ce, 0);
    start = 1'b1;
    step(); step();
    chk("held_rst_busy", busy, 0);
    chk("held_rst_phase", phase_increment, 0);
    $display("reset held with start: busy=%0d phase=%0d", busy, phase_increment);
    start = 1'b0;
    arst  = 1'b0;
    step();
    chk("post_rst_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/nco_sweep_controller.md
# nco_sweep_controller

Sequencer that drives the phase-increment and clock-enable inputs of the sine/cosine NCO to perform stepped frequency sweeps (chirps/hops) without processor involvement. It latches a sweep descriptor on a start pulse and holds each frequency for a programmable number of sample-clock enables. It then steps the increment, in single-shot or continuous mode. It sits between the control/register interface and the NCO, on the same clock and sample-enable as the NCO.

## Interface
- PHASE_WIDTH, 64, width of phase increment (matches NCO accumulator)
- COUNT_WIDTH, 16, width of step count and step index
- DWELL_WIDTH, 16, width of dwell length in sample enables
- clk  in  1  system clock
- arst  in  1  reset; synchronous and active-high; sampled on rising edge of clk
- sample_clk_ce  in  1  sample-rate enable, same strobe the NCO uses
- start  in  1  one-cycle request to begin a sweep; ignored unless IDLE
- abort  in  1  stop sweep immediately; priority over start
- cont_mode  in  1  0 = single-shot, 1 = restart from start_increment after last step
- start_increment  in  PHASE_WIDTH  first increment (unsigned, modulo 2^PHASE_WIDTH)
- step_increment  in  PHASE_WIDTH  signed delta added per step (negative = down-sweep)
- num_steps  in  COUNT_WIDTH  number of frequencies in sweep; 0 treated as 1
- dwell_samples  in  DWELL_WIDTH  sample enables per frequency; 0 treated as 1
- phase_increment  out  PHASE_WIDTH  registered, to NCO phase_increment
- nco_ce  out  1  sample_clk_ce gated by busy, to NCO sample_clk_ce
- busy  out  1  high while in DWELL
- done  out  1  one-cycle pulse at end of single-shot sweep
- step_index  out  COUNT_WIDTH  index of current frequency, 0-based

## Operation
- States: IDLE, DWELL, DONE. Reset → IDLE; all outputs 0 (phase_increment=0, step_index=0, busy=0, done=0, nco_ce=0).
- IDLE: start=1 and abort=0 → latch cont_mode, start_increment, step_increment, num_steps, dwell_samples into shadow registers; phase_increment←start_increment; step_index←0; dwell counter←0; → DWELL. Descriptor inputs may change after the latch without effect.
- DWELL: each sample_clk_ce increments the dwell counter. On the ce at which the counter equals max(dwell_samples,1)−1, the block takes one of these actions:
  - not last step: phase_increment←phase_increment+step_increment (wraps modulo 2^PHASE_WIDTH, no saturation); step_index+1; counter←0.
  - last step (step_index = max(num_steps,1)−1), cont_mode=1: phase_increment←start_increment; step_index←0; counter←0; remain DWELL.
  - last step, cont_mode=0: → DONE; phase_increment holds final value.
- DONE: done=1 for exactly one cycle → IDLE.
- abort=1 in any state: next edge → IDLE, phase_increment←0, step_index←0, counter←0. No done pulse.
- start while DWELL/DONE is ignored; it is not queued.
- busy = (state==DWELL); done = (state==DONE); both are decoded from the state register.
- nco_ce = sample_clk_ce & busy (combinational). The NCO phase therefore freezes outside a sweep.
- arst has priority over abort and start.

## Timing
- start sampled at edge N → from N+1: busy=1 and phase_increment=start_increment. The first nco_ce that the NCO uses is the first sample_clk_ce at or after N+1.
- The increment update lands on the same edge as the final dwell ce. The next nco_ce therefore always uses the new value, with no sample at a stale frequency.
- Single-shot sweep: exactly max(num_steps,1)·max(dwell_samples,1) nco_ce pulses. Final ce at edge E → DONE during E..E+1, done=1 for that cycle, IDLE from E+1. start is accepted again at edge E+1.
- abort sampled at edge A → busy=0, nco_ce=0 and phase_increment=0 from A.
- Reset asserted mid-sweep → all outputs at reset values after that edge. With arst=1 held, start has no effect.

## Test plan
- Reset mid-sweep: run a sweep, assert arst one cycle → phase_increment=0, busy=0, done=0, step_index=0 next cycle. With arst held high, start pulses are ignored.
- Single-shot up-sweep: start_increment=1000, step_increment=+250, num_steps=4, dwell_samples=3, sample_clk_ce every 2nd cycle.
  - The bench must see 12 nco_ce pulses: increments 1000×3, 1250×3, 1500×3, 1750×3.
  - done is a single pulse after the 12th nce_ce edge; phase_increment stays at 1750.
- Down-sweep with wrap: PHASE_WIDTH=64, start_increment=100, step_increment=−200, num_steps=2, dwell=1 → increments 100, then 2^64−100.
- Continuous mode: num_steps=3, dwell=2, cont_mode=1 → step_index runs 0,0,1,1,2,2,0,0,…, with no done pulse. abort then gives busy=0, phase_increment=0 on the next cycle and no done.
- Degenerate descriptor: num_steps=0, dwell_samples=0 → exactly one nco_ce at start_increment, then a done pulse.
- Handshake: start during DWELL is ignored, and changing descriptor inputs mid-sweep leaves the outputs unchanged. Simultaneous start and abort in IDLE → remains IDLE.
